out_video_pipe: RTL
===================

// Module: out_video_pipe
// PURPOSE
//  Output-side video pipeline stage: delays HSYNC/VSYNC/DE/RGB by a parametrised
//  number of clocks, blanks RGB outside DE, and emits per-pixel X/Y coordinates
//  and a start-of-frame pulse aligned with the delayed stream. Sits at the end of
//  the video path, ahead of the display encoder, and replaces single-register output stages.
// PARAMETERS
//  PIXEL_WIDTH  8   bits per colour channel
//  LATENCY      2   clocks from input sample to output; legal 1..16 (1 = plain register)
//  HCNT_WIDTH   12  width of oX
//  VCNT_WIDTH   11  width of oY
//  VSYNC_POL    1   1: iVSYNC active-high; 0: active-low (HSYNC passed through untouched)
//  BLANK        1   1: force oR0/oG0/oB0 to 0 whenever oDE=0; 0: pass RGB through raw
// PORTS
//  CLK        in   1            pixel clock
//  RST_N      in   1            asynchronous, active-low reset
//  iHSYNC     in   1            horizontal sync
//  iVSYNC     in   1            vertical sync
//  iDE        in   1            data enable (active pixel)
//  iR0/iG0/iB0 in  PIXEL_WIDTH  pixel colour
//  oHSYNC/oVSYNC/oDE out 1      delayed sync/enable
//  oR0/oG0/oB0 out PIXEL_WIDTH  delayed (optionally blanked / overlaid) colour
//  oX         out  HCNT_WIDTH   column of the pixel on oR0..oB0 (valid when oDE=1)
//  oY         out  VCNT_WIDTH   row of the pixel on oR0..oB0 (valid when oDE=1)
//  oSOF       out  1            1-clock pulse with the first oDE=1 pixel of a frame
// BEHAVIOUR
//  - Reset: every output 0; all pipeline stages, counters and marker registers 0; first_line flag = 1.
//  - Input sampled on CLK rising edge n appears on outputs after edge n+LATENCY-1 (LATENCY registers deep).
//  - Sync/DE/RGB delayed identically. No per-signal skew is allowed.
//  - Coordinate stage (first register stage) computes x/y/sof:
//    - vs_act = iVSYNC ^ ~VSYNC_POL. A rising edge of vs_act sets first_line=1.
//    - iDE=1 with previous DE=0 (line start):
//      - x=0.
//      - If first_line: y=0, sof=1, and first_line is cleared.
//      - Otherwise: y=y+1 (saturating at all-ones).
//    - iDE=1 with previous DE=1: x=x+1 (saturating at all-ones). No wrap is allowed.
//    - iDE=0: x and y hold; sof=0.
//  - x/y/sof travel the remaining LATENCY-1 stages alongside the data.
//  - Blanking: with BLANK=1, RGB is forced to 0 in the last stage whenever DE=0 there.
//  - Reset mid-frame: the next line seen reports Y=0 and oSOF=1, even without a VSYNC edge.
//  - DE glitch of one clock counts as a full line (x=0, y advances). Upstream guarantees clean DE.
// CONFIGURATION
//  Macro OUT_VIDEO_MARKER_EN: crosshair overlay for eye-position display.
//  - Defined: the following ports are added.
//    - iMARK_ON (1)
//    - iMARK_X (HCNT_WIDTH)
//    - iMARK_Y (VCNT_WIDTH)
//    - iMARK_RGB (3*PIXEL_WIDTH, {R,G,B})
//  - Defined, marker latching: the marker inputs are latched on each vs_act rising edge (tear-free).
//  - Defined, overlay rule: in the last stage, if latched ON && DE && (x==MX || y==MY), RGB = latched colour.
//    - Latency is unchanged.
//    - Marker colour is applied before blanking, so the marker is never visible in blanking.
//  - Undefined: marker ports, registers and compare logic are absent; RGB is a pure delay.
// TESTING
//  1. LATENCY=1, BLANK=0 -> out == in delayed 1 clk, bit-exact over a random stream; oX/oY still count.
//  2. LATENCY=4, 8x4 active frame after VSYNC pulse -> oDE high 4 clk after iDE.
//     - oX runs 0..7 per line; oY runs 0..3.
//     - oSOF is high only with (0,0).
//  3. BLANK=1, iR0=8'hAA with iDE=0 -> oR0=0; with iDE=1 -> oR0=8'hAA after LATENCY.
//  4. RST_N pulsed low mid-line 2 -> outputs 0 immediately (async).
//     - Next line gives oY=0 and oSOF=1 without VSYNC.
//  5. HCNT_WIDTH=3, 10-pixel line -> oX = 0..7, then holds 7 for pixels 8 and 9.
//  6. OUT_VIDEO_MARKER_EN, mark (2,1), colour 24'hFF0000, marker changed mid-frame
//     - Column 2 and row 1 are red; all other pixels pass through.
//     - The new mark applies from the next frame only.

Source files
------------

// File: rtl/out_video_pipe.sv
// Output video stage: LATENCY-deep delay of sync/DE/RGB with per-pixel X/Y, SOF and blanking.
// Optional crosshair overlay when OUT_VIDEO_MARKER_EN is defined.
module out_video_pipe #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LATENCY     = 2,
  parameter int HCNT_WIDTH  = 12,
  parameter int VCNT_WIDTH  = 11,
  parameter bit VSYNC_POL   = 1'b1,
  parameter bit BLANK       = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     iHSYNC,
  input  logic                     iVSYNC,
  input  logic                     iDE,
  input  logic [PIXEL_WIDTH-1:0]   iR0,
  input  logic [PIXEL_WIDTH-1:0]   iG0,
  input  logic [PIXEL_WIDTH-1:0]   iB0,
`ifdef OUT_VIDEO_MARKER_EN
  input  logic                     iMARK_ON,
  input  logic [HCNT_WIDTH-1:0]    iMARK_X,
  input  logic [VCNT_WIDTH-1:0]    iMARK_Y,
  input  logic [3*PIXEL_WIDTH-1:0] iMARK_RGB,
`endif
  output logic                     oHSYNC,
  output logic                     oVSYNC,
  output logic                     oDE,
  output logic [PIXEL_WIDTH-1:0]   oR0,
  output logic [PIXEL_WIDTH-1:0]   oG0,
  output logic [PIXEL_WIDTH-1:0]   oB0,
  output logic [HCNT_WIDTH-1:0]    oX,
  output logic [VCNT_WIDTH-1:0]    oY,
  output logic                     oSOF
);

  localparam int CW = 3 * PIXEL_WIDTH;

  logic                  hs_q  [LATENCY];
  logic                  vs_q  [LATENCY];
  logic                  de_q  [LATENCY];
  logic                  sof_q [LATENCY];
  logic [CW-1:0]         rgb_q [LATENCY];
  logic [HCNT_WIDTH-1:0] x_q   [LATENCY];
  logic [VCNT_WIDTH-1:0] y_q   [LATENCY];

  logic                  hs_d  [LATENCY];
  logic                  vs_d  [LATENCY];
  logic                  de_d  [LATENCY];
  logic                  sof_d [LATENCY];
  logic [CW-1:0]         rgb_d [LATENCY];
  logic [HCNT_WIDTH-1:0] x_d   [LATENCY];
  logic [VCNT_WIDTH-1:0] y_d   [LATENCY];

  logic                  vs_act;
  logic                  vs_rise;
  logic                  vs_prev_q;
  logic                  first_line_q;
  logic                  first_line_d;
  logic [HCNT_WIDTH-1:0] x_nxt;
  logic [VCNT_WIDTH-1:0] y_nxt;
  logic                  sof_nxt;
  logic [CW-1:0]         rgb_last;

`ifdef OUT_VIDEO_MARKER_EN
  logic                  mark_on_q;
  logic [HCNT_WIDTH-1:0] mark_x_q;
  logic [VCNT_WIDTH-1:0] mark_y_q;
  logic [CW-1:0]         mark_rgb_q;
`endif

  assign vs_act  = iVSYNC ^ ~VSYNC_POL;
  assign vs_rise = vs_act & ~vs_prev_q;

  // Stage 0 doubles as the coordinate state; de_q[0] is the previous DE.
  always_comb begin
    x_nxt        = x_q[0];
    y_nxt        = y_q[0];
    sof_nxt      = 1'b0;
    first_line_d = first_line_q;
    if (iDE) begin
      if (!de_q[0]) begin
        x_nxt = '0;
        if (first_line_q) begin
          y_nxt        = '0;
          sof_nxt      = 1'b1;
          first_line_d = 1'b0;
        end else if (y_q[0] != '1) begin
          y_nxt = y_q[0] + 1'b1;
        end
      end else if (x_q[0] != '1) begin
        x_nxt = x_q[0] + 1'b1;
      end
    end
    if (vs_rise) first_line_d = 1'b1;
  end

  always_comb begin
    hs_d[0]  = iHSYNC;
    vs_d[0]  = iVSYNC;
    de_d[0]  = iDE;
    sof_d[0] = sof_nxt;
    rgb_d[0] = {iR0, iG0, iB0};
    x_d[0]   = x_nxt;
    y_d[0]   = y_nxt;
    for (int k = 1; k < LATENCY; k++) begin
      hs_d[k]  = hs_q[k-1];
      vs_d[k]  = vs_q[k-1];
      de_d[k]  = de_q[k-1];
      sof_d[k] = sof_q[k-1];
      rgb_d[k] = rgb_q[k-1];
      x_d[k]   = x_q[k-1];
      y_d[k]   = y_q[k-1];
    end
  end

  // Overlay first, then blanking, so the marker can never leak into blanking.
  always_comb begin
    rgb_last = rgb_d[LATENCY-1];
`ifdef OUT_VIDEO_MARKER_EN
    if (mark_on_q && de_d[LATENCY-1] &&
        (x_d[LATENCY-1] == mark_x_q || y_d[LATENCY-1] == mark_y_q)) begin
      rgb_last = mark_rgb_q;
    end
`endif
    if (BLANK && !de_d[LATENCY-1]) rgb_last = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_line_q <= 1'b1;
      vs_prev_q    <= 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
        hs_q[k]  <= 1'b0;
        vs_q[k]  <= 1'b0;
        de_q[k]  <= 1'b0;
        sof_q[k] <= 1'b0;
        rgb_q[k] <= '0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
      end
`ifdef OUT_VIDEO_MARKER_EN
      mark_on_q  <= 1'b0;
      mark_x_q   <= '0;
      mark_y_q   <= '0;
      mark_rgb_q <= '0;
`endif
    end else begin
      first_line_q <= first_line_d;
      vs_prev_q    <= vs_act;
      for (int k = 0; k < LATENCY; k++) begin
        hs_q[k]  <= hs_d[k];
        vs_q[k]  <= vs_d[k];
        de_q[k]  <= de_d[k];
        sof_q[k] <= sof_d[k];
        rgb_q[k] <= (k == LATENCY - 1) ? rgb_last : rgb_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
      end
`ifdef OUT_VIDEO_MARKER_EN
      // Latch only at frame start so a mid-frame change cannot tear the crosshair.
      if (vs_rise) begin
        mark_on_q  <= iMARK_ON;
        mark_x_q   <= iMARK_X;
        mark_y_q   <= iMARK_Y;
        mark_rgb_q <= iMARK_RGB;
      end
`endif
    end
  end

  assign oHSYNC = hs_q[LATENCY-1];
  assign oVSYNC = vs_q[LATENCY-1];
  assign oDE    = de_q[LATENCY-1];
  assign oSOF   = sof_q[LATENCY-1];
  assign oX     = x_q[LATENCY-1];
  assign oY     = y_q[LATENCY-1];
  assign oR0    = rgb_q[LATENCY-1][CW-1 -: PIXEL_WIDTH];
  assign oG0    = rgb_q[LATENCY-1][2*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
  assign oB0    = rgb_q[LATENCY-1][PIXEL_WIDTH-1:0];

endmodule
